// File: rtl/ram_dp_clr_if.sv
// Bus bundle for ram_dp_clr: both RAM ports plus the clear/status signals.
// The master drives addresses, data and enables. The slave (the RAM) drives
// read data, range flags and status.
interface ram_dp_clr_if #(
  parameter int unsigned wordsize = 64,
  parameter int unsigned addrsize = 9
) ();

  localparam int unsigned lanes = wordsize / 8;

  // Clear control and status
  logic                clr;
  logic                busy;
  logic                coll;

  // Port A
  logic [addrsize-1:0] addrA;
  logic                wEnA;
  logic [lanes-1:0]    beA;
  logic [wordsize-1:0] wDatA;
  logic                rEnA;
  logic [wordsize-1:0] rDatA;
  logic                errA;

  // Port B
  logic [addrsize-1:0] addrB;
  logic                wEnB;
  logic [lanes-1:0]    beB;
  logic [wordsize-1:0] wDatB;
  logic                rEnB;
  logic [wordsize-1:0] rDatB;
  logic                errB;

  modport master (
    output clr,
    output addrA, wEnA, beA, wDatA, rEnA,
    output addrB, wEnB, beB, wDatB, rEnB,
    input  busy, coll,
    input  rDatA, errA,
    input  rDatB, errB
  );

  modport slave (
    input  clr,
    input  addrA, wEnA, beA, wDatA, rEnA,
    input  addrB, wEnB, beB, wDatB, rEnB,
    output busy, coll,
    output rDatA, errA,
    output rDatB, errB
  );

endinterface

// File: rtl/ram_dp_clr.sv
// Dual-ported RAM with per-byte write enables, gated reads, out-of-range
// flags, port-A-wins collision resolution and a hardware clear sequencer.
// Used as instruction/data memory in the Y86 processor models.
//
// Build option: define RAM_SYNCREAD_EN to register rDatA/rDatB (1-cycle
// latency, old data on a same-cycle write). Without it, reads are
// combinational.
module ram_dp_clr #(
  parameter int unsigned wordsize  = 64,
  parameter int unsigned wordcount = 512,
  parameter int unsigned addrsize  = 9
) (
  input  logic        clock,
  input  logic        resetn,
  ram_dp_clr_if.slave bus
);

  localparam int unsigned lanes = wordsize / 8;

  // FSM encoding
  localparam logic [0:0] CLEAR = 1'b0;
  localparam logic [0:0] READY = 1'b1;

  // One extra bit so an address equal to wordcount compares correctly
  localparam logic [addrsize:0]   wordLimit = (addrsize + 1)'(wordcount);
  localparam logic [addrsize-1:0] lastAddr  = addrsize'(wordcount - 1);

  logic [0:0]          stateQ, stateD;
  logic [addrsize-1:0] cntQ, cntD;
  logic                collQ, collD;

  logic                ready;
  logic                errA, errB;
  logic                wrA, wrB;
  logic                sameAddr;
  logic [lanes-1:0]    laneA, laneB;   // lanes each port actually commits
  logic [lanes-1:0]    reqB;           // lanes B asks for, before arbitration

  logic [wordsize-1:0] mem [wordcount];
  logic [wordsize-1:0] readA, readB;

  // ---------------------------------------------------------------------------
  // Address checks and write qualification
  // ---------------------------------------------------------------------------
  assign ready    = (stateQ == READY);
  assign errA     = ({1'b0, bus.addrA} >= wordLimit);
  assign errB     = ({1'b0, bus.addrB} >= wordLimit);
  assign wrA      = ready & bus.wEnA & ~errA;
  assign wrB      = ready & bus.wEnB & ~errB;
  assign sameAddr = (bus.addrA == bus.addrB);

  // Resolve per-lane write ownership; A takes any lane both ports want
  always_comb begin
    laneA = '0;
    reqB  = '0;
    laneB = '0;
    if (wrA) begin
      laneA = bus.beA;
    end
    if (wrB) begin
      reqB = bus.beB;
    end
    if (sameAddr) begin
      laneB = reqB & ~laneA;
    end else begin
      laneB = reqB;
    end
  end

  // A collision is flagged only for real overlapping writes while READY
  always_comb begin
    collD = 1'b0;
    if (ready && sameAddr && ((laneA & reqB) != '0)) begin
      collD = 1'b1;
    end
  end

  // ---------------------------------------------------------------------------
  // Clear sequencer
  // ---------------------------------------------------------------------------
  // Next-state: walk the counter through every word, then idle in READY
  always_comb begin
    stateD = stateQ;
    cntD   = cntQ;
    case (stateQ)
      CLEAR: begin
        if (cntQ == lastAddr) begin
          cntD   = '0;
          stateD = READY;
        end else begin
          cntD = cntQ + 1'b1;
        end
      end
      default: begin
        // clr is only looked at here, so a request during CLEAR cannot restart it
        if (bus.clr) begin
          stateD = CLEAR;
        end
      end
    endcase
  end

  // State, clear counter and collision pulse registers
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      stateQ <= CLEAR;
      cntQ   <= '0;
      collQ  <= 1'b0;
    end else begin
      stateQ <= stateD;
      cntQ   <= cntD;
      collQ  <= collD;
    end
  end

  // ---------------------------------------------------------------------------
  // Storage
  // ---------------------------------------------------------------------------
  // Memory update: clear one word per cycle, or commit the arbitrated lanes.
  // Contents are deliberately not reset; the clear sequence zeroes them.
  always_ff @(posedge clock) begin
    if (!ready) begin
      mem[cntQ] <= '0;
    end else begin
      for (int i = 0; i < lanes; i++) begin
        if (laneA[i]) begin
          mem[bus.addrA][8*i +: 8] <= bus.wDatA[8*i +: 8];
        end
        if (laneB[i]) begin
          mem[bus.addrB][8*i +: 8] <= bus.wDatB[8*i +: 8];
        end
      end
    end
  end

  // Gated read data: zero unless enabled, in range and not clearing
  always_comb begin
    readA = '0;
    readB = '0;
    if (ready && bus.rEnA && !errA) begin
      readA = mem[bus.addrA];
    end
    if (ready && bus.rEnB && !errB) begin
      readB = mem[bus.addrB];
    end
  end

`ifdef RAM_SYNCREAD_EN
  logic [wordsize-1:0] rDatAQ, rDatBQ;

  // Registered read ports; nonblocking sampling returns pre-write data
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      rDatAQ <= '0;
      rDatBQ <= '0;
    end else begin
      rDatAQ <= readA;
      rDatBQ <= readB;
    end
  end

  assign bus.rDatA = rDatAQ;
  assign bus.rDatB = rDatBQ;
`else
  assign bus.rDatA = readA;
  assign bus.rDatB = readB;
`endif

  // ---------------------------------------------------------------------------
  // Status outputs
  // ---------------------------------------------------------------------------
  assign bus.busy = ~ready;
  assign bus.coll = collQ;
  assign bus.errA = errA;
  assign bus.errB = errB;

endmodule

// File: tb/tb_ram_dp_clr.sv
// Directed bench for ram_dp_clr: clear timing, byte-lane writes, collision
// priority, range flags, read gating and clear/reset restart. Works in both
// read modes; the read-mode macro selects when read data is sampled.
module tb_ram_dp_clr;

  localparam int unsigned WS = 64;
  localparam int unsigned WC = 20;
  localparam int unsigned AW = 5;

  logic clock = 1'b0;
  logic resetn;

  always #5 clock = ~clock;

  ram_dp_clr_if #(.wordsize(WS), .addrsize(AW)) bus ();

  ram_dp_clr #(
    .wordsize (WS),
    .wordcount(WC),
    .addrsize (AW)
  ) dut (
    .clock (clock),
    .resetn(resetn),
    .bus   (bus)
  );

  typedef struct packed {
    logic          wEnA;
    logic [AW-1:0] addrA;
    logic [7:0]    beA;
    logic [63:0]   wDatA;
    logic          rEnA;
    logic          wEnB;
    logic [AW-1:0] addrB;
    logic [7:0]    beB;
    logic [63:0]   wDatB;
    logic          rEnB;
    logic [63:0]   expA;
    logic          expErrA;
    logic [63:0]   expB;
    logic          expErrB;
    logic          expColl;
  } vec_t;

  localparam int NVEC = 14;
  vec_t vecs [NVEC];

  int checks   = 0;
  int failures = 0;
  bit syncMode;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic setIdle();
    bus.clr   = 1'b0;
    bus.addrA = '0; bus.wEnA = 1'b0; bus.beA = '0; bus.wDatA = '0; bus.rEnA = 1'b0;
    bus.addrB = '0; bus.wEnB = 1'b0; bus.beB = '0; bus.wDatB = '0; bus.rEnB = 1'b0;
  endtask

  // Colliding writes plus a read of a loaded word, held while a clear runs
  task automatic clearStim();
    bus.addrA = 5'd5; bus.wEnA = 1'b1; bus.beA = 8'hFF; bus.wDatA = 64'hDEADBEEF_CAFEF00D;
    bus.rEnA  = 1'b1;
    bus.addrB = 5'd5; bus.wEnB = 1'b1; bus.beB = 8'hFF; bus.wDatB = 64'h0BADF00D_12345678;
    bus.rEnB  = 1'b0;
  endtask

  // Count edges until busy drops; pulses clr mid-way to show it is ignored
  task automatic waitClear(output int n, output bit sawColl, output logic [63:0] rd2);
    n       = 0;
    sawColl = 1'b0;
    rd2     = 64'hFFFF_FFFF_FFFF_FFFF;
    while (bus.busy && n < 200) begin
      @(posedge clock);
      #1;
      n++;
      if (bus.coll) sawColl = 1'b1;
      if (n == 2) rd2 = bus.rDatA;
      bus.clr = (n == 3);
    end
    bus.clr = 1'b0;
  endtask

  task automatic readCheck(input int addr, input logic [63:0] exp, input string name);
    @(negedge clock);
    bus.addrA = addr[AW-1:0];
    bus.rEnA  = 1'b1;
    bus.wEnA  = 1'b0;
    bus.beA   = '0;
    #1;
    if (syncMode) begin
      @(posedge clock);
      #1;
    end
    check(name, bus.rDatA, exp);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog timeout checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    bit sawColl;
    logic [63:0] rd2;

`ifdef RAM_SYNCREAD_EN
    syncMode = 1'b1;
`else
    syncMode = 1'b0;
`endif

    // wEnA addrA beA wDatA rEnA | wEnB addrB beB wDatB rEnB | expA errA expB errB coll
    vecs[0]  = {1'b1, 5'd5,  8'h0F, 64'h1122334455667788, 1'b1,
                1'b0, 5'd0,  8'h00, 64'h0,                1'b0,
                64'h0, 1'b0, 64'h0, 1'b0, 1'b0};
    vecs[1]  = {1'b0, 5'd5,  8'h00, 64'h0,                1'b1,
                1'b0, 5'd3,  8'h00, 64'h0,                1'b1,
                64'h0000000055667788, 1'b0, 64'h0, 1'b0, 1'b0};
    vecs[2]  = {1'b1, 5'd3,  8'hFF, 64'hAAAAAAAAAAAAAAAA, 1'b1,
                1'b1, 5'd3,  8'hFF, 64'hBBBBBBBBBBBBBBBB, 1'b1,
                64'h0, 1'b0, 64'h0, 1'b0, 1'b1};
    vecs[3]  = {1'b0, 5'd3,  8'h00, 64'h0,                1'b1,
                1'b0, 5'd3,  8'h00, 64'h0,                1'b1,
                64'hAAAAAAAAAAAAAAAA, 1'b0, 64'hAAAAAAAAAAAAAAAA, 1'b0, 1'b0};
    vecs[4]  = {1'b1, 5'd7,  8'h0F, 64'h1111111111111111, 1'b1,
                1'b1, 5'd7,  8'hF0, 64'h2222222222222222, 1'b0,
                64'h0, 1'b0, 64'h0, 1'b0, 1'b0};
    vecs[5]  = {1'b0, 5'd7,  8'h00, 64'h0,                1'b1,
                1'b0, 5'd5,  8'h00, 64'h0,                1'b1,
                64'h2222222211111111, 1'b0, 64'h0000000055667788, 1'b0, 1'b0};
    vecs[6]  = {1'b1, 5'd20, 8'hFF, 64'hFFFFFFFFFFFFFFFF, 1'b1,
                1'b1, 5'd20, 8'hFF, 64'hEEEEEEEEEEEEEEEE, 1'b1,
                64'h0, 1'b1, 64'h0, 1'b1, 1'b0};
    vecs[7]  = {1'b0, 5'd5,  8'h00, 64'h0,                1'b0,
                1'b0, 5'd3,  8'h00, 64'h0,                1'b1,
                64'h0, 1'b0, 64'hAAAAAAAAAAAAAAAA, 1'b0, 1'b0};
    vecs[8]  = {1'b1, 5'd9,  8'h03, 64'h0101010101010101, 1'b1,
                1'b1, 5'd9,  8'h06, 64'h0202020202020202, 1'b0,
                64'h0, 1'b0, 64'h0, 1'b0, 1'b1};
    vecs[9]  = {1'b0, 5'd9,  8'h00, 64'h0,                1'b1,
                1'b0, 5'd7,  8'h00, 64'h0,                1'b1,
                64'h0000000000020101, 1'b0, 64'h2222222211111111, 1'b0, 1'b0};
    vecs[10] = {1'b1, 5'd1,  8'hFF, 64'h0123456789ABCDEF, 1'b1,
                1'b1, 5'd0,  8'h80, 64'hCCDDEEFF00112233, 1'b1,
                64'h0, 1'b0, 64'h0, 1'b0, 1'b0};
    vecs[11] = {1'b0, 5'd0,  8'h00, 64'h0,                1'b1,
                1'b0, 5'd1,  8'h00, 64'h0,                1'b1,
                64'hCC00000000000000, 1'b0, 64'h0123456789ABCDEF, 1'b0, 1'b0};
    vecs[12] = {1'b1, 5'd5,  8'h00, 64'hFFFFFFFFFFFFFFFF, 1'b1,
                1'b1, 5'd5,  8'h00, 64'hFFFFFFFFFFFFFFFF, 1'b1,
                64'h0000000055667788, 1'b0, 64'h0000000055667788, 1'b0, 1'b0};
    vecs[13] = {1'b0, 5'd5,  8'h00, 64'h0,                1'b1,
                1'b0, 5'd19, 8'h00, 64'h0,                1'b1,
                64'h0000000055667788, 1'b0, 64'h0, 1'b0, 1'b0};

    // Reset state and initial clear length
    resetn = 1'b0;
    setIdle();
    repeat (3) @(negedge clock);
    #1;
    check("reset busy", {63'h0, bus.busy}, 64'h1);
    check("reset coll", {63'h0, bus.coll}, 64'h0);
    check("reset rDatA", bus.rDatA, 64'h0);
    @(negedge clock);
    resetn = 1'b1;
    clearStim();
    waitClear(n, sawColl, rd2);
    setIdle();
    check("init clear cycles", 64'(n), 64'(WC));
    check("init clear coll", {63'h0, sawColl}, 64'h0);
    check("init clear rDatA gated", rd2, 64'h0);

    for (int a = 0; a < WC; a++) begin
      readCheck(a, 64'h0, $sformatf("zero after init addr%0d", a));
    end

    // Table of single-cycle operations in READY
    for (int i = 0; i < NVEC; i++) begin
      @(negedge clock);
      bus.wEnA = vecs[i].wEnA; bus.addrA = vecs[i].addrA; bus.beA = vecs[i].beA;
      bus.wDatA = vecs[i].wDatA; bus.rEnA = vecs[i].rEnA;
      bus.wEnB = vecs[i].wEnB; bus.addrB = vecs[i].addrB; bus.beB = vecs[i].beB;
      bus.wDatB = vecs[i].wDatB; bus.rEnB = vecs[i].rEnB;
      #1;
      check($sformatf("vec%0d errA", i), {63'h0, bus.errA}, {63'h0, vecs[i].expErrA});
      check($sformatf("vec%0d errB", i), {63'h0, bus.errB}, {63'h0, vecs[i].expErrB});
      if (!syncMode) begin
        check($sformatf("vec%0d rDatA", i), bus.rDatA, vecs[i].expA);
        check($sformatf("vec%0d rDatB", i), bus.rDatB, vecs[i].expB);
      end
      @(posedge clock);
      #1;
      check($sformatf("vec%0d coll", i), {63'h0, bus.coll}, {63'h0, vecs[i].expColl});
      if (syncMode) begin
        check($sformatf("vec%0d rDatA", i), bus.rDatA, vecs[i].expA);
        check($sformatf("vec%0d rDatB", i), bus.rDatB, vecs[i].expB);
      end
    end
    setIdle();

    // clr pulse in READY with data loaded
    @(negedge clock);
    #1;
    check("ready before clr", {63'h0, bus.busy}, 64'h0);
    bus.clr = 1'b1;
    @(posedge clock);
    #1;
    check("busy after clr", {63'h0, bus.busy}, 64'h1);
    bus.clr = 1'b0;
    clearStim();
    waitClear(n, sawColl, rd2);
    setIdle();
    check("clr clear cycles", 64'(n), 64'(WC));
    check("clr clear coll", {63'h0, sawColl}, 64'h0);
    check("clr clear rDatA gated", rd2, 64'h0);
    readCheck(0, 64'h0, "zero after clr addr0");
    readCheck(3, 64'h0, "zero after clr addr3");
    readCheck(5, 64'h0, "zero after clr addr5");
    readCheck(7, 64'h0, "zero after clr addr7");
    readCheck(9, 64'h0, "zero after clr addr9");

    // resetn pulsed mid-clear restarts the full sequence
    @(negedge clock);
    bus.clr = 1'b1;
    @(posedge clock);
    #1;
    bus.clr = 1'b0;
    repeat (5) @(posedge clock);
    #1;
    resetn = 1'b0;
    #1;
    check("midclear reset busy", {63'h0, bus.busy}, 64'h1);
    check("midclear reset coll", {63'h0, bus.coll}, 64'h0);
    @(negedge clock);
    resetn = 1'b1;
    clearStim();
    waitClear(n, sawColl, rd2);
    setIdle();
    check("restart clear cycles", 64'(n), 64'(WC));
    readCheck(5, 64'h0, "zero after restart addr5");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
